// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 16
) ();
    logic                 req0;
    logic                 we0;
    logic [ADDR_SIZE-1:0] addr0;
    logic [WORD_SIZE-1:0] wdata0;
    logic                 gnt0;
    logic                 rvalid0;
    logic [WORD_SIZE-1:0] rdata0;

    logic                 req1;
    logic                 we1;
    logic [ADDR_SIZE-1:0] addr1;
    logic [WORD_SIZE-1:0] wdata1;
    logic                 gnt1;
    logic                 rvalid1;
    logic [WORD_SIZE-1:0] rdata1;

    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data_in;
    logic                 mem_we;
    logic                 mem_oe;
    logic [WORD_SIZE-1:0] mem_data_out;
    logic                 busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_data_out,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_data_in, mem_we, mem_oe, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_data_out,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_data_in, mem_we, mem_oe, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous-read memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t               state_q, state_d;
    logic                 port_q, port_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [WORD_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d, oe_q, oe_d, busy_q, busy_d;
    logic                 winner;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    logic                 last_q, last_d;

    // On a collision the port not granted last time wins.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last_q;
        end
    end
`else
    always_comb begin
        winner = ~bus.req0;
    end
`endif

    always_comb begin
        sel_we    = winner ? bus.we1    : bus.we0;
        sel_addr  = winner ? bus.addr1  : bus.addr0;
        sel_wdata = winner ? bus.wdata1 : bus.wdata0;
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        oe_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    port_d  = winner;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    oe_d    = ~sel_we;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_d  = winner;
`endif
                end
            end
            // Memory samples at the end of this cycle; we/oe drop with the defaults.
            ACCESS: begin
                state_d = we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (port_q) begin
                    rdata1_d  = bus.mem_data_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.mem_data_out;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_oe      = oe_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural synchronous-read memory
// and a read-data scoreboard per port.
module tb_mem_arbiter;
    localparam int unsigned W = 16;
    localparam int unsigned A = 16;

    logic clk = 1'b0;
    logic rst_n;

    mem_arbiter_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();

    mem_arbiter #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: registered read when oe & !we, cleared by reset.
    logic [W-1:0] mem_model [0:65535];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 65536; i++) mem_model[i] <= '0;
            bus.mem_data_out <= '0;
        end else begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_data_in;
            if (bus.mem_oe && !bus.mem_we) bus.mem_data_out <= mem_model[bus.mem_addr];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit hold   = 1'b0;
    int gnt0_cyc, gnt1_cyc, rv0_cyc, rv1_cyc;
    int gnt_order [$];
    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];
    logic [W-1:0] got0 [$];
    logic [W-1:0] got1 [$];
    logic [W-1:0] exp_mem [int];

    function automatic logic [W-1:0] mem_val(input logic [A-1:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : W'(0);
    endfunction

    // Advance one cycle, then observe: record grants/read data, release granted requests.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        n_cmp++;
        if (bus.mem_we && bus.mem_oe) begin
            n_fail++;
            $display("FAIL we_oe_exclusive: cycle %0d mem_we=1 mem_oe=1, required not both", cyc);
        end
        if (bus.gnt0) begin
            gnt0_cyc = cyc;
            gnt_order.push_back(0);
            if (!hold) bus.req0 = 1'b0;
        end
        if (bus.gnt1) begin
            gnt1_cyc = cyc;
            gnt_order.push_back(1);
            if (!hold) bus.req1 = 1'b0;
        end
        if (bus.rvalid0) begin
            rv0_cyc = cyc;
            got0.push_back(bus.rdata0);
        end
        if (bus.rvalid1) begin
            rv1_cyc = cyc;
            got1.push_back(bus.rdata1);
        end
    endtask

    task automatic issue(input bit port, input bit we, input logic [A-1:0] addr,
                         input logic [W-1:0] data);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
        end
        if (we) exp_mem[int'(addr)] = data;
        else if (port) exp1.push_back(mem_val(addr));
        else exp0.push_back(mem_val(addr));
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((bus.req0 || bus.req1 || bus.busy) && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic xfer(input bit port, input bit we, input logic [A-1:0] addr,
                        input logic [W-1:0] data);
        issue(port, we, addr, data);
        drain(20);
    endtask

    task automatic clear_markers();
        gnt0_cyc = -1; gnt1_cyc = -1; rv0_cyc = -1; rv1_cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            bus.req0 = 1'($urandom); bus.we0 = 1'($urandom);
            bus.addr0 = A'($urandom); bus.wdata0 = W'($urandom);
            bus.req1 = 1'($urandom); bus.we1 = 1'($urandom);
            bus.addr1 = A'($urandom); bus.wdata1 = W'($urandom);
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_we, bus.mem_oe, bus.busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt0,gnt1,rv0,rv1,we,oe,busy=%b, required 0000000",
                     {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_we, bus.mem_oe, bus.busy});
        end
        n_cmp++;
        if (bus.rdata0 !== W'(0) || bus.rdata1 !== W'(0)) begin
            n_fail++;
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required 0", bus.rdata0, bus.rdata1);
        end
        n_cmp++;
        if (bus.mem_addr !== A'(0) || bus.mem_data_in !== W'(0)) begin
            n_fail++;
            $display("FAIL reset_mem_bus: addr=%h data_in=%h, required 0", bus.mem_addr, bus.mem_data_in);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int t0 = cyc;
        clear_markers();
        issue(0, 1'b1, 16'h0010, 16'hBEEF);
        step();
        n_cmp++;
        if (!(bus.gnt0 === 1'b1 && bus.mem_we === 1'b1 && bus.mem_oe === 1'b0)) begin
            n_fail++;
            $display("FAIL wr_grant: gnt0=%b we=%b oe=%b, required 1 1 0", bus.gnt0, bus.mem_we, bus.mem_oe);
        end
        n_cmp++;
        if (bus.mem_addr !== 16'h0010 || bus.mem_data_in !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL wr_bus: addr=%h data=%h, required 0010 beef", bus.mem_addr, bus.mem_data_in);
        end
        step();
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: we=%b busy=%b in cycle 2, required 0 0", bus.mem_we, bus.busy);
        end
        issue(1, 1'b0, 16'h0010, 16'h0);
        step();
        n_cmp++;
        if (bus.gnt1 !== 1'b1 || bus.mem_oe !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_grant: gnt1=%b oe=%b we=%b in cycle 3, required 1 1 0", bus.gnt1, bus.mem_oe, bus.mem_we);
        end
        step();
        n_cmp++;
        if (bus.mem_oe !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_capture: oe=%b busy=%b in cycle 4, required 0 1", bus.mem_oe, bus.busy);
        end
        step();
        n_cmp++;
        if (rv1_cyc - t0 != 5) begin
            n_fail++;
            $display("FAIL rd_latency: rvalid1 at rel cycle %0d, required 5", rv1_cyc - t0);
        end
        n_cmp++;
        if (got1.size() == 0 || exp1.size() == 0) begin
            n_fail++;
            $display("FAIL rd_data: got %0d results, required 1", got1.size());
        end else if (got1[0] !== exp1[0]) begin
            n_fail++;
            $display("FAIL rd_data: rdata1=%h, required %h", got1[0], exp1[0]);
        end
        got1.delete(); exp1.delete();
    endtask

    task automatic test_collision();
        int t0;
        xfer(0, 1'b1, 16'h0001, 16'h1111);
        xfer(1, 1'b1, 16'h0002, 16'h2222);
        clear_markers();
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        t0 = cyc;
        issue(0, 1'b0, 16'h0001, 16'h0);
        issue(1, 1'b0, 16'h0002, 16'h0);
        repeat (8) step();
        n_cmp++;
        if (gnt0_cyc - t0 != 1 || rv0_cyc - t0 != 3) begin
            n_fail++;
            $display("FAIL coll_port0: gnt0 rel %0d rvalid0 rel %0d, required 1 3", gnt0_cyc - t0, rv0_cyc - t0);
        end
        n_cmp++;
        if (gnt1_cyc - t0 != 4 || rv1_cyc - t0 != 6) begin
            n_fail++;
            $display("FAIL coll_port1: gnt1 rel %0d rvalid1 rel %0d, required 4 6", gnt1_cyc - t0, rv1_cyc - t0);
        end
        n_cmp++;
        if (got0.size() != 1 || got0[0] !== exp0[0]) begin
            n_fail++;
            $display("FAIL coll_data0: %0d results first=%h, required 1 result %h",
                     got0.size(), (got0.size() > 0) ? got0[0] : W'(0), exp0[0]);
        end
        n_cmp++;
        if (got1.size() != 1 || got1[0] !== exp1[0]) begin
            n_fail++;
            $display("FAIL coll_data1: %0d results first=%h, required 1 result %h",
                     got1.size(), (got1.size() > 0) ? got1[0] : W'(0), exp1[0]);
        end
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic test_starvation();
        int exp_order [4];
        int n = 0;
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        gnt_order.delete();
        hold = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0020; bus.wdata0 = 16'hA000;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0021; bus.wdata1 = 16'hB000;
        while (gnt_order.size() < 4 && n < 40) begin
            step();
            n++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        hold = 1'b0;
        drain(20);
        n_cmp++;
        if (gnt_order.size() < 4) begin
            n_fail++;
            $display("FAIL starve_count: %0d grants, required 4", gnt_order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (gnt_order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL starve_order: grant %0d went to port %0d, required port %0d",
                             i, gnt_order[i], exp_order[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_boundary();
        got1.delete(); exp1.delete();
        issue(1, 1'b1, 16'hFFFF, 16'h1234);
        step();
        n_cmp++;
        if (bus.gnt1 !== 1'b1 || bus.mem_addr !== 16'hFFFF || bus.mem_data_in !== 16'h1234) begin
            n_fail++;
            $display("FAIL bnd_write: gnt1=%b addr=%h data=%h, required 1 ffff 1234",
                     bus.gnt1, bus.mem_addr, bus.mem_data_in);
        end
        drain(20);
        xfer(1, 1'b0, 16'hFFFF, 16'h0);
        xfer(1, 1'b0, 16'h0000, 16'h0);
        n_cmp++;
        if (got1.size() != 2) begin
            n_fail++;
            $display("FAIL bnd_count: %0d read results, required 2", got1.size());
        end else begin
            if (got1[0] !== exp1[0]) begin
                n_fail++;
                $display("FAIL bnd_ffff: rdata1=%h, required %h", got1[0], exp1[0]);
            end
            n_cmp++;
            if (got1[1] !== exp1[1]) begin
                n_fail++;
                $display("FAIL bnd_0000: rdata1=%h, required %h", got1[1], exp1[1]);
            end
        end
        got1.delete(); exp1.delete();
    endtask

    task automatic test_reset_capture();
        got0.delete(); exp0.delete();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        step();
        step();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_pre: busy=%b rvalid0=%b in capture, required 1 0", bus.busy, bus.rvalid0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.rvalid0, bus.mem_oe, bus.mem_we} !== 4'b0 || bus.rdata0 !== W'(0)) begin
            n_fail++;
            $display("FAIL rc_reset: busy,rv0,oe,we=%b rdata0=%h, required 0000 0000",
                     {bus.busy, bus.rvalid0, bus.mem_oe, bus.mem_we}, bus.rdata0);
        end
        step();
        rst_n = 1'b1;
        exp_mem.delete();
        step();
        step();
        n_cmp++;
        if (got0.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_no_rvalid: %0d rvalid0 pulses busy=%b, required 0 0", got0.size(), bus.busy);
        end
        got0.delete();
        xfer(0, 1'b0, 16'h0010, 16'h0);
        n_cmp++;
        if (got0.size() != 1 || got0[0] !== exp0[0]) begin
            n_fail++;
            $display("FAIL rc_fresh_read: %0d results first=%h, required 1 result %h",
                     got0.size(), (got0.size() > 0) ? got0[0] : W'(0), exp0[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        clear_markers();
        #3;
        test_reset();
        test_write_read();
        test_collision();
        test_starvation();
        test_boundary();
        test_reset_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port system memory: port 0 is the instruction fetch, port 1 is the data load/store.
- Accepts one request at a time, drives the memory's addr/data_in/we/oe, and returns read data with a valid pulse.
- The memory has a synchronous read: `data_out` is registered when `oe & !we` at a clock edge.
- Sits between the CPU front end and the memory instance; the memory's own reset is driven separately.

Parameters:
- WORD_SIZE, 16, data width in bits; must match the memory.
- ADDR_SIZE, 16, address width in bits; must match the memory.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until gnt0 is seen.
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  ADDR_SIZE  port 0 address.
- wdata0  in  WORD_SIZE  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- rvalid0  out  1  one-cycle pulse: rdata0 is valid.
- rdata0  out  WORD_SIZE  port 0 read data; held until the next port 0 read.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1.
- mem_addr  out  ADDR_SIZE  to memory addr.
- mem_data_in  out  WORD_SIZE  to memory data_in.
- mem_we  out  1  to memory we.
- mem_oe  out  1  to memory oe.
- mem_data_out  in  WORD_SIZE  from memory data_out.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; all gnt, rvalid, mem_we, mem_oe and busy are 0; mem_addr, mem_data_in, rdata0 and rdata1 are 0; last-grant register = port 1.
- States:
  - IDLE: if req0 or req1 is high, select the winner and register mem_addr, mem_data_in, mem_we=we_x, mem_oe=!we_x, and gnt_x=1. Go to ACCESS. With no request, stay in IDLE with mem_we=mem_oe=0.
  - ACCESS: memory signals are stable this cycle; the memory samples at the end of it. gnt_x returns to 0.
    - Write: clear mem_we and go to IDLE.
    - Read: clear mem_oe and go to CAPTURE.
  - CAPTURE: mem_data_out is valid this cycle. Register it into rdata_x, set rvalid_x=1 for the next cycle, and go to IDLE.
- Read timing, with the request sampled in IDLE at cycle 0:
  - gnt in cycle 1.
  - Memory data valid in cycle 2.
  - rvalid/rdata in cycle 3.
  - Next request can be sampled in cycle 3.
- Write timing: gnt and mem_we=1 in cycle 1; the memory is written at the end of cycle 1; the next request can be sampled in cycle 2.
- Maximum throughput: one write per 2 cycles, one read per 3 cycles.
- Requester rule: deassert req, or present the next request, in the cycle after gnt. A req still high in that cycle counts as a new request.
- Arbitration with simultaneous requests: fixed priority, port 0 wins (see Optional Feature). A request arriving in ACCESS or CAPTURE waits; it is never dropped or reordered.
- mem_we and mem_oe are never high in the same cycle. A mem_oe=1 cycle is never back-to-back with the next transaction's mem_we.
- Address range: all ADDR_SIZE bits pass through unchanged. Address 0xFFFF is legal; there is no increment and no wrap logic.
- Reset mid-operation (rst_n low in any state): immediate return to reset values. An in-flight read produces no rvalid; an in-flight write may or may not reach the memory. No partial outputs after rst_n rises.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, grant the port not in the last-grant register; update that register on every grant. A single requester is always granted.
- Undefined: fixed priority, port 0 wins. The last-grant register and its logic are absent.

Test Plan:
- Reset: hold rst_n=0 three cycles with random inputs -> all gnt, rvalid, mem_we and mem_oe are 0, busy=0, rdata0=rdata1=0.
- Write then read:
  - Port 0 write addr=0x0010, data=0xBEEF at cycle 0 -> gnt0, mem_we=1 and mem_addr=0x0010 in cycle 1; mem_oe=0.
  - Then port 1 read 0x0010 sampled at cycle 2 -> gnt1 in cycle 3, rvalid1=1 with rdata1=0xBEEF in cycle 5.
- Collision, fixed priority (macro off): both ports read at cycle 0, port 0 addr=0x0001, port 1 addr=0x0002 -> gnt0 in cycle 1, rvalid0 in cycle 3, gnt1 in cycle 4, rvalid1 in cycle 6.
- Starvation vs round-robin: both ports request continuously for 4 transactions -> macro off: gnt1 never pulses; macro on: grant order 0,1,0,1.
- Boundary address: port 1 write addr=0xFFFF, data=0x1234, then port 1 read 0xFFFF -> rdata1=0x1234; addr 0x0000 is unchanged.
- Reset in CAPTURE: port 0 read of 0x0010 (holding 0xBEEF); pull rst_n low in cycle 2 -> no rvalid0 pulse, rdata0=0, state IDLE; after release, a fresh read returns 0 (memory also reset).
